// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide side datapath.
package mips_pkg;

   localparam int WIDTH = 32;

   // Decoder uses these to drive start/signed_op of the HI/LO unit.
   localparam logic [5:0] FUNCT_MULT  = 6'h18;
   localparam logic [5:0] FUNCT_MULTU = 6'h19;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/mult_hilo_unit_if.sv
// Request/result bundle between the issue logic and the HI/LO multiplier.
interface mult_hilo_unit_if;
   import mips_pkg::*;

   logic             start;
   logic             signed_op;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             ready;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, signed_op, op_a, op_b,
      input  ready, done, hi, lo
   );

   modport slave (
      input  start, signed_op, op_a, op_b,
      output ready, done, hi, lo
   );

endinterface

// File: rtl/mult_hilo_unit_adder.sv
// 32-bit ripple adder shared by the datapath; no carry-out port.
module adder #(
   parameter int W = 32
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o
);

   logic carry;

   // Bit-serial carry chain.
   always_comb begin
      sum_o = '0;
      carry = cin_i;
      for (int i = 0; i < W; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
   end

endmodule

// File: rtl/mult_hilo_unit.sv
// Multi-cycle shift-add multiplier for mult/multu, result held in HI/LO.
//
// state     | meaning
// ST_IDLE   | ready, waiting for start
// ST_BUSY   | one shift-add iteration per edge, 32 edges
// ST_FINISH | apply sign, load HI/LO, pulse done
module mult_hilo_unit
   import mips_pkg::*;
#(
   parameter int CNT_W = 5
) (
   input  logic          clk,
   input  logic          reset,
   mult_hilo_unit_if.slave bus
);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] p_q;
   logic [WIDTH-1:0]   m_q;
   logic               neg_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               ready_q;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   sum;
   logic               cout;
   logic [2*WIDTH-1:0] p_d;
   logic [2*WIDTH-1:0] res_d;

   adder #(.W(WIDTH)) u_adder (
      .a_i   (p_q[2*WIDTH-1:WIDTH]),
      .b_i   (m_q),
      .cin_i (1'b0),
      .sum_o (sum)
   );

   // Operand magnitudes; 0x80000000 maps to itself, read as unsigned.
   always_comb begin
      mag_a = bus.op_a;
      mag_b = bus.op_b;
      if (bus.signed_op && bus.op_a[WIDTH-1]) mag_a = ~bus.op_a + 1'b1;
      if (bus.signed_op && bus.op_b[WIDTH-1]) mag_b = ~bus.op_b + 1'b1;
   end

   // One iteration step plus the final sign fix-up. The adder has no
   // carry-out, so it is rebuilt from the top bits of the operands and sum.
   always_comb begin
      cout = (p_q[2*WIDTH-1] & m_q[WIDTH-1])
           | ((p_q[2*WIDTH-1] | m_q[WIDTH-1]) & ~sum[WIDTH-1]);
      if (p_q[0]) p_d = {cout, sum, p_q[WIDTH-1:1]};
      else        p_d = {1'b0, p_q[2*WIDTH-1:1]};
      res_d = neg_q ? (~p_q + 1'b1) : p_q;
   end

   // Control FSM with datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         p_q     <= '0;
         m_q     <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  state_q <= ST_BUSY;
                  ready_q <= 1'b0;
                  p_q     <= {{WIDTH{1'b0}}, mag_b};
                  m_q     <= mag_a;
                  neg_q   <= bus.signed_op & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                  cnt_q   <= '0;
               end
            end
            ST_BUSY: begin
               p_q   <= p_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(WIDTH-1)) state_q <= ST_FINISH;
            end
            ST_FINISH: begin
               hi_q    <= res_d[2*WIDTH-1:WIDTH];
               lo_q    <= res_d[WIDTH-1:0];
               done_q  <= 1'b1;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Directed and random checks of the HI/LO multiplier against an arithmetic model.
module tb_mult_hilo_unit;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   logic [63:0] last_prod = 64'd0;

   mult_hilo_unit_if bus();

   mult_hilo_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
      logic signed [63:0] sa;
      logic signed [63:0] sb;
      logic [63:0] ua;
      logic [63:0] ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      return s ? 64'(sa * sb) : 64'(ua * ub);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation; optionally present a stray start at busy cycle inj.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int inj);
      logic [63:0] exp;
      int lat;
      exp = model(a, b, s);
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = s; bus.op_a = a; bus.op_b = b;
      @(negedge clk);
      bus.start = 1'b0;
      chk("busy_ready", 64'(bus.ready), 64'd0);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == inj) begin
            bus.start = 1'b1; bus.signed_op = 1'b0; bus.op_a = 32'd9; bus.op_b = 32'd9;
         end
         @(negedge clk);
         bus.start = 1'b0;
         if (k == 5) chk("hold_busy", {bus.hi, bus.lo}, last_prod);
         if (bus.done) begin
            lat = k;
            break;
         end
      end
      chk("latency", 64'(lat), 64'd33);
      chk("done_ready", 64'(bus.ready), 64'd1);
      chk("hilo", {bus.hi, bus.lo}, exp);
      last_prod = exp;
      @(negedge clk);
      chk("done_pulse", 64'(bus.done), 64'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      int seen;
      bus.start = 1'b0; bus.signed_op = 1'b0; bus.op_a = '0; bus.op_b = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(bus.ready), 64'd1);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);

      run_op(32'd7, 32'd6, 1'b0, 0);
      chk("7x6_exact", {bus.hi, bus.lo}, 64'h0000_0000_0000_002A);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
      chk("ff_u_exact", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
      run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 0);
      chk("m1x2_exact", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0);
      chk("min_sq_exact", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);
      run_op(32'd0, 32'hFFFF_FFFB, 1'b1, 0);
      chk("zero_neg", {bus.hi, bus.lo}, 64'd0);

      for (int i = 0; i < 12; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 3) ra[31] = 1'b1;
         run_op(ra, rb, 1'($urandom_range(0, 1)), 0);
      end

      // Stray start during BUSY must not disturb 3x5.
      run_op(32'd3, 32'd5, 1'b0, 10);
      chk("ignored_lo", 64'(bus.lo), 64'h0000_000F);

      // Reset in the middle of an operation discards it and clears HI/LO.
      @(negedge clk);
      bus.start = 1'b1; bus.signed_op = 1'b0; bus.op_a = 32'd3; bus.op_b = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
      chk("midrst_ready", 64'(bus.ready), 64'd1);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      chk("midrst_nodone", 64'(seen), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
